// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the register-file read ports, the control
// unit and the iterative multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, rsData, rtData, input hi, lo, busy, done);
  modport slave  (input start, op, rsData, rtData, output hi, lo, busy, done);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// One shift-add / restore-subtract step per cycle on a 64-bit accumulator,
// operating on magnitudes; signs are re-applied in the FIX state.
// Optional macro MDU_DIV_EN compiles in the divider (DIV/DIVU); without it
// ops 3/4 behave as NOP.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic           CLK,
  input  logic           RST_N,
  mult_div_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2;
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, done_q, done_d;
`ifdef MDU_DIV_EN
  logic               is_div_q, is_div_d;
  logic [WIDTH:0]     diff;
`endif
  logic               go, sgn;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Request decode: which ops launch the FSM, and operand magnitudes.
  always_comb begin
    go = 1'b0;
    if (state_q == S_IDLE && bus.start)
      go = (bus.op == OP_MULT) || (bus.op == OP_MULTU)
`ifdef MDU_DIV_EN
        || (bus.op == OP_DIV) || (bus.op == OP_DIVU)
`endif
        ;
    sgn   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_abs = (sgn && bus.rsData[WIDTH-1]) ? -bus.rsData : bus.rsData;
    b_abs = (sgn && bus.rtData[WIDTH-1]) ? -bus.rtData : bus.rtData;
  end

  // FSM next-state, iteration datapath and HI/LO writeback.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    done_d   = 1'b0;
    sum      = '0;
    prod     = '0;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    diff     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, a_abs};
          b_d      = b_abs;
          neg_a_d  = sgn && bus.rsData[WIDTH-1];
          neg_b_d  = sgn && bus.rtData[WIDTH-1];
`ifdef MDU_DIV_EN
          is_div_d = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`endif
        end else if (state_q == S_IDLE && bus.start && bus.op == OP_MTHI) begin
          hi_d = bus.rsData;
        end else if (state_q == S_IDLE && bus.start && bus.op == OP_MTLO) begin
          lo_d = bus.rsData;
        end
      end
      S_CALC: begin
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          // Shift partial remainder left, subtract divisor if it fits.
          diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
          if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else
`endif
        begin
          // Add multiplicand on LSB, shift right keeping the carry.
          sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          // Remainder follows the dividend sign; with a zero divisor this
          // reproduces the original rs value.
          hi_d = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          if (b_q == '0) lo_d = '1;
          else lo_d = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else
`endif
        begin
          prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then drop start.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start = 1'b1; bus.op = op; bus.rsData = rs; bus.rtData = rt;
    @(posedge CLK); #1;
    bus.start = 1'b0; bus.op = 3'd0;
  endtask

  // Launch an op, watch the busy window, compare against the scoreboard.
  // inj_at > 0 pulses an MTHI request at that busy cycle (must be ignored).
  // Returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [63:0] exp, input int inj_at);
    logic [63:0] old;
    int busy_cnt, done_cnt;
    bit hold_ok;
    old = {bus.hi, bus.lo};
    sb_q.push_back(exp);
    busy_cnt = 0; done_cnt = 0; hold_ok = 1'b1;
    issue(op, rs, rt);
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (i == inj_at) begin bus.start = 1'b1; bus.op = 3'd5; bus.rsData = 32'h1234; end
      if (i == inj_at + 1) bus.start = 1'b0;
      if (!bus.busy) break;
      busy_cnt++;
      if (bus.done) done_cnt++;
      if ({bus.hi, bus.lo} !== old) hold_ok = 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_early_done"}, 64'(done_cnt), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_result"}, {bus.hi, bus.lo}, sb_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit bad;
    logic [63:0] old;
    bus.start = 1'b0; bus.op = 3'd0; bus.rsData = '0; bus.rtData = '0;
    #3;
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);

    run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 0);
    @(negedge CLK);
    chk("mult_done_one_cycle", 64'(bus.done), 64'd0);
    chk("mult_idle", 64'(bus.busy), 64'd0);

    run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0);
    // MTLO in the done cycle
    issue(3'd6, 32'd5, 32'd0);
    @(negedge CLK);
    chk("mtlo_b2b_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000005);
    chk("mtlo_b2b_busy", 64'(bus.busy), 64'd0);
    chk("mtlo_b2b_done", 64'(bus.done), 64'd0);

    issue(3'd5, 32'h0000ABCD, 32'd0);
    @(negedge CLK);
    chk("mthi_hilo", {bus.hi, bus.lo}, 64'h0000ABCD_00000005);
    issue(3'd7, 32'hDEAD, 32'd1);
    issue(3'd0, 32'hBEEF, 32'd1);
    @(negedge CLK);
    chk("nop_hilo", {bus.hi, bus.lo}, 64'h0000ABCD_00000005);
    chk("nop_busy", 64'(bus.busy), 64'd0);

`ifdef MDU_DIV_EN
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
    run_op("div_negdiv", 3'd3, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0);
    run_op("divu_7", 3'd4, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
    run_op("divu_zero", 3'd4, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 0);
    run_op("div_zero_neg", 3'd3, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 0);
`else
    old = {bus.hi, bus.lo};
    issue(3'd4, 32'd100, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.busy || bus.done) bad = 1'b1;
    end
    chk("divu_disabled_quiet", 64'(bad), 64'd0);
    chk("divu_disabled_hilo", {bus.hi, bus.lo}, old);
`endif
    @(negedge CLK);

    run_op("multu_ign_mthi", 3'd2, 32'd3, 32'd4, 64'h00000000_0000000C, 10);
    @(negedge CLK);
    chk("ign_done_clear", 64'(bus.done), 64'd0);

    // Asynchronous reset in the middle of a MULT
    issue(3'd1, 32'd5, 32'd6);
    repeat (15) @(negedge CLK);
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge CLK); RST_N = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.busy || bus.done) bad = 1'b1;
    end
    chk("post_rst_quiet", 64'(bad), 64'd0);
    chk("post_rst_hilo", {bus.hi, bus.lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
